sensor_avg_bank: RTL and testbench

//  Parametrised multi-channel exponential averager for conditioned bike sensors (torque, curr, batt, incline).

---
 rtl/sensor_avg_bank_if.sv | 28 ++
 rtl/sensor_avg_bank.sv | 111 +++++++++++
 tb/tb_sensor_avg_bank.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sensor_avg_bank_if.sv
// Sample/average bus for sensor_avg_bank. The master side supplies samples and config.
// The slave side (the averager) returns the averages and status.
interface sensor_avg_bank_if #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 12,
    parameter int MAX_SHIFT = 7
);
    localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);

    logic [NUM_CH*DATA_W-1:0]  smpl_in;
    logic                      smpl_vld;
    logic [NUM_CH*SHIFT_W-1:0] shift_cfg;
    logic                      clr_ovr;
    logic [NUM_CH*DATA_W-1:0]  avg_out;
    logic                      avg_vld;
    logic                      busy;
    logic                      ovr;

    modport master (
        output smpl_in, smpl_vld, shift_cfg, clr_ovr,
        input  avg_out, avg_vld, busy, ovr
    );

    modport slave (
        input  smpl_in, smpl_vld, shift_cfg, clr_ovr,
        output avg_out, avg_vld, busy, ovr
    );
endinterface

// File: rtl/sensor_avg_bank.sv
// Multi-channel exponential averager with per-channel weight 1/2^k.
// All channels are captured on a strobe, then updated one per cycle through a shared adder.
module sensor_avg_bank #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 12,
    parameter int MAX_SHIFT = 7
) (
    input  logic             clk,
    input  logic             rst,
    sensor_avg_bank_if.slave bus
);
    localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);
    localparam int ACC_W   = DATA_W + MAX_SHIFT;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [SHIFT_W-1:0] K_MAX   = SHIFT_W'(MAX_SHIFT);
    localparam logic [CH_W-1:0]    LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, next_state;

    logic [CH_W-1:0]    ch_idx;
    logic [DATA_W-1:0]  snap_smpl [NUM_CH];
    logic [SHIFT_W-1:0] snap_k    [NUM_CH];
    logic [ACC_W-1:0]   acc       [NUM_CH];
    logic [SHIFT_W-1:0] k_last    [NUM_CH];
    logic [DATA_W-1:0]  avg_q     [NUM_CH];
    logic [NUM_CH-1:0]  primed;
    logic               ovr_q;

    logic               capture;
    logic               busy_int;
    logic               seed;
    logic [DATA_W-1:0]  x_cur;
    logic [SHIFT_W-1:0] k_cur;
    logic [ACC_W-1:0]   acc_cur;
    logic [ACC_W-1:0]   acc_new;

    function automatic logic [SHIFT_W-1:0] clamp_k(input logic [SHIFT_W-1:0] k);
        return (k > K_MAX) ? K_MAX : k;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.smpl_vld) next_state = CALC;
            CALC:    if (ch_idx == LAST_CH) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign capture  = (state == IDLE) && bus.smpl_vld;
    assign busy_int = (state != IDLE);

    // Shared update path: a change of exponent restarts the channel from the new sample.
    always_comb begin
        x_cur   = snap_smpl[ch_idx];
        k_cur   = snap_k[ch_idx];
        acc_cur = acc[ch_idx];
        seed    = !primed[ch_idx] || (k_cur != k_last[ch_idx]);
        if (seed) acc_new = ACC_W'(x_cur) << k_cur;
        else      acc_new = acc_cur - (acc_cur >> k_cur) + ACC_W'(x_cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx <= '0;
            primed <= '0;
            ovr_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_smpl[i] <= '0;
                snap_k[i]    <= '0;
                acc[i]       <= '0;
                k_last[i]    <= '0;
                avg_q[i]     <= '0;
            end
        end else begin
            if (capture) begin
                ch_idx <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    snap_smpl[i] <= bus.smpl_in[i*DATA_W +: DATA_W];
                    snap_k[i]    <= clamp_k(bus.shift_cfg[i*SHIFT_W +: SHIFT_W]);
                end
            end
            if (state == CALC) begin
                acc[ch_idx]    <= acc_new;
                primed[ch_idx] <= 1'b1;
                k_last[ch_idx] <= k_cur;
                avg_q[ch_idx]  <= DATA_W'(acc_new >> k_cur);
                if (ch_idx != LAST_CH) ch_idx <= ch_idx + CH_W'(1);
            end
            // A dropped strobe wins over a simultaneous clear.
            if (bus.smpl_vld && busy_int) ovr_q <= 1'b1;
            else if (bus.clr_ovr)         ovr_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign bus.avg_out[g*DATA_W +: DATA_W] = avg_q[g];
    end

    assign bus.avg_vld = (state == DONE);
    assign bus.busy    = busy_int;
    assign bus.ovr     = ovr_q;
endmodule

// File: tb/tb_sensor_avg_bank.sv
// Directed bench for sensor_avg_bank (4 channels, 12-bit, k up to 7).
// Expected averages are hand-computed from the exponential update rule.
module tb_sensor_avg_bank;
    logic clk;
    logic rst;

    int vec_count = 0;
    int err_count = 0;
    int cyc;
    int bcnt;
    int nvld;

    // ch0 k=3, ch1 k=2, ch2 k=0, ch3 k=7; CFG_B moves ch1 to k=4
    localparam logic [11:0] CFG_A = 12'hE13;
    localparam logic [11:0] CFG_B = 12'hE23;

    sensor_avg_bank_if #(.NUM_CH(4), .DATA_W(12), .MAX_SHIFT(7)) bus ();

    sensor_avg_bank #(.NUM_CH(4), .DATA_W(12), .MAX_SHIFT(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [47:0] pack4(input logic [11:0] c3, input logic [11:0] c2,
                                          input logic [11:0] c1, input logic [11:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [11:0] avgCh(input int i);
        return bus.avg_out[i*12 +: 12];
    endfunction

    task automatic checkAvg(input string tag, input logic [11:0] e0, input logic [11:0] e1,
                            input logic [11:0] e2, input logic [11:0] e3);
        checkOutput($sformatf("%s_ch0", tag), 32'(avgCh(0)), 32'(e0));
        checkOutput($sformatf("%s_ch1", tag), 32'(avgCh(1)), 32'(e1));
        checkOutput($sformatf("%s_ch2", tag), 32'(avgCh(2)), 32'(e2));
        checkOutput($sformatf("%s_ch3", tag), 32'(avgCh(3)), 32'(e3));
    endtask

    // Called on a negedge; returns on the negedge after the strobe cycle.
    task automatic applyStimulus(input logic [47:0] smpl, input logic [11:0] cfg);
        bus.smpl_in   = smpl;
        bus.shift_cfg = cfg;
        bus.smpl_vld  = 1'b1;
        tick();
        bus.smpl_vld  = 1'b0;
    endtask

    // Counts negedges (including the current one) until avg_vld, bounded.
    task automatic waitDone(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            cycles++;
            if (bus.busy) busy_cnt++;
            if (bus.avg_vld) break;
            tick();
        end
        checkOutput("avg_vld_seen", 32'(bus.avg_vld), 32'd1);
    endtask

    task automatic countVld(input int ncyc, output int seen);
        seen = 0;
        for (int n = 0; n < ncyc; n++) begin
            tick();
            if (bus.avg_vld) seen++;
        end
    endtask

    task automatic strobeAndCheck(input string tag, input logic [47:0] smpl, input logic [11:0] cfg,
                                  input logic [11:0] e0, input logic [11:0] e1,
                                  input logic [11:0] e2, input logic [11:0] e3);
        applyStimulus(smpl, cfg);
        waitDone(cyc, bcnt);
        checkAvg(tag, e0, e1, e2, e3);
        tick();
    endtask

    initial begin
        logic [11:0] s1 [4];
        logic [11:0] e1 [4];
        s1 = '{12'h000, 12'h800, 12'h800, 12'h800};
        e1 = '{12'h000, 12'h200, 12'h380, 12'h4A0};

        rst           = 1'b1;
        bus.smpl_in   = '0;
        bus.smpl_vld  = 1'b0;
        bus.shift_cfg = '0;
        bus.clr_ovr   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        checkAvg("rst", 12'h000, 12'h000, 12'h000, 12'h000);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_avg_vld", 32'(bus.avg_vld), 32'd0);
        checkOutput("rst_ovr", 32'(bus.ovr), 32'd0);

        // Test 1: seed with latency and busy window
        applyStimulus(pack4(12'hFFF, 12'h000, 12'h000, 12'h2FF), CFG_A);
        waitDone(cyc, bcnt);
        checkOutput("t1_latency", 32'(cyc), 32'd5);
        checkOutput("t1_busy_cycles", 32'(bcnt), 32'd5);
        checkAvg("t1", 12'h2FF, 12'h000, 12'h000, 12'hFFF);
        tick();
        checkOutput("t1_busy_after", 32'(bus.busy), 32'd0);
        checkOutput("t1_vld_after", 32'(bus.avg_vld), 32'd0);

        // Test 2: ch1 k=2 step response
        for (int i = 0; i < 4; i++)
            strobeAndCheck($sformatf("t2_%0d", i), pack4(12'hFFF, 12'h000, s1[i], 12'h2FF), CFG_A,
                           12'h2FF, e1[i], 12'h000, 12'hFFF);

        // Test 3: ch2 pass-through and ch3 at the largest exponent
        strobeAndCheck("t3a", pack4(12'hFFF, 12'h123, 12'h4A0, 12'h2FF), CFG_A,
                       12'h2FF, 12'h4A0, 12'h123, 12'hFFF);
        strobeAndCheck("t3b", pack4(12'hFFF, 12'hABC, 12'h4A0, 12'h2FF), CFG_A,
                       12'h2FF, 12'h4A0, 12'hABC, 12'hFFF);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(pack4(12'hFFF, 12'hABC, 12'h4A0, 12'h2FF), CFG_A);
            waitDone(cyc, bcnt);
            checkOutput($sformatf("t3_ch3_%0d", i), 32'(avgCh(3)), 32'hFFF);
            tick();
        end

        // Test 4: overrun drops the sample, sticky flag, clear priority
        checkOutput("t4_ovr_pre", 32'(bus.ovr), 32'd0);
        applyStimulus(pack4(12'hFFF, 12'h055, 12'h4A0, 12'h2FF), CFG_A);
        tick();
        bus.smpl_in  = pack4(12'hFFF, 12'h0AA, 12'h4A0, 12'h2FF);
        bus.smpl_vld = 1'b1;
        tick();
        bus.smpl_vld = 1'b0;
        checkOutput("t4_ovr_set", 32'(bus.ovr), 32'd1);
        waitDone(cyc, bcnt);
        checkOutput("t4_latency", 32'(cyc), 32'd3);
        checkAvg("t4", 12'h2FF, 12'h4A0, 12'h055, 12'hFFF);
        countVld(10, nvld);
        checkOutput("t4_no_extra_vld", 32'(nvld), 32'd0);
        checkOutput("t4_ovr_sticky", 32'(bus.ovr), 32'd1);

        applyStimulus(pack4(12'hFFF, 12'h055, 12'h4A0, 12'h2FF), CFG_A);
        tick();
        bus.smpl_vld = 1'b1;
        bus.clr_ovr  = 1'b1;
        tick();
        bus.smpl_vld = 1'b0;
        bus.clr_ovr  = 1'b0;
        checkOutput("t4_set_beats_clr", 32'(bus.ovr), 32'd1);
        waitDone(cyc, bcnt);
        tick();
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        checkOutput("t4_clr_alone", 32'(bus.ovr), 32'd0);

        // Test 6: reset in the second CALC cycle aborts the sequence
        applyStimulus(pack4(12'hFFF, 12'h055, 12'h4A0, 12'h2FF), CFG_A);
        bus.smpl_vld = 1'b1;
        tick();
        bus.smpl_vld = 1'b0;
        checkOutput("t6_ovr_before_rst", 32'(bus.ovr), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAvg("t6_rst", 12'h000, 12'h000, 12'h000, 12'h000);
        checkOutput("t6_busy", 32'(bus.busy), 32'd0);
        checkOutput("t6_ovr", 32'(bus.ovr), 32'd0);
        checkOutput("t6_vld", 32'(bus.avg_vld), 32'd0);
        countVld(8, nvld);
        checkOutput("t6_no_vld", 32'(nvld), 32'd0);

        strobeAndCheck("t6_reseed", pack4(12'hFFF, 12'h321, 12'h000, 12'h2FF), CFG_A,
                       12'h2FF, 12'h000, 12'h321, 12'hFFF);

        // Test 5: exponent change re-seeds ch1
        strobeAndCheck("t5_a", pack4(12'hFFF, 12'h321, 12'h800, 12'h2FF), CFG_A,
                       12'h2FF, 12'h200, 12'h321, 12'hFFF);
        strobeAndCheck("t5_b", pack4(12'hFFF, 12'h321, 12'h800, 12'h2FF), CFG_A,
                       12'h2FF, 12'h380, 12'h321, 12'hFFF);
        strobeAndCheck("t5_k4", pack4(12'hFFF, 12'h321, 12'h100, 12'h2FF), CFG_B,
                       12'h2FF, 12'h100, 12'h321, 12'hFFF);
        strobeAndCheck("t5_k4_hold", pack4(12'hFFF, 12'h321, 12'h100, 12'h2FF), CFG_B,
                       12'h2FF, 12'h100, 12'h321, 12'hFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
